// File: rtl/clint_mh.sv
// rtl/clint_mh.sv - multi-hart core local interruptor with prescaled shared mtime
module clint_mh #(
   parameter int XLEN      = 64,
   parameter int NUM_HARTS = 2,
   parameter int ADDR_W    = 4,
   parameter int TICK_DIV  = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   en_i,
   input  logic                   we_i,
   input  logic [ADDR_W-1:0]      addr_i,
   input  logic [XLEN/8-1:0]      be_i,
   input  logic [XLEN-1:0]        data_i,
   output logic [XLEN-1:0]        data_o,
   output logic                   data_ready_o,
   input  logic                   stop_i,
   output logic [NUM_HARTS-1:0]   tmr_irq_o,
   output logic [NUM_HARTS-1:0]   sft_irq_o
);

   // A one-bit prescaler is kept even for TICK_DIV = 1; it simply stays at 0.
   localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

   logic [XLEN-1:0]      mtime;
   logic [PW-1:0]        presc;
   logic [XLEN-1:0]      mtimecmp [NUM_HARTS];
   logic [NUM_HARTS-1:0] msip;

   logic [XLEN-1:0]      rd_val;
   logic                 mtime_wr;
   logic [NUM_HARTS-1:0] cmp_wr;
   logic [NUM_HARTS-1:0] sip_wr;

   // Byte-lane merge of write data into an existing register value.
   function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old,
                                             input logic [XLEN-1:0] d,
                                             input logic [XLEN/8-1:0] be);
      logic [XLEN-1:0] r;
      r = old;
      for (int i = 0; i < XLEN/8; i++) begin
         if (be[i]) r[8*i +: 8] = d[8*i +: 8];
      end
      return r;
   endfunction

   // Address decode: read mux of current register values and per-register write strobes.
   always_comb begin
      rd_val   = '0;
      mtime_wr = 1'b0;
      cmp_wr   = '0;
      sip_wr   = '0;
      if (addr_i == '0) begin
         rd_val   = mtime;
         mtime_wr = en_i & we_i;
      end
      for (int h = 0; h < NUM_HARTS; h++) begin
         if (addr_i == ADDR_W'(1 + h)) begin
            rd_val    = mtimecmp[h];
            cmp_wr[h] = en_i & we_i;
         end
         if (addr_i == ADDR_W'(1 + NUM_HARTS + h)) begin
            rd_val    = {{(XLEN-1){1'b0}}, msip[h]};
            sip_wr[h] = en_i & we_i;
         end
      end
   end

   // mtime and prescaler: a bus write wins over the tick and restarts the prescaler.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mtime <= '0;
         presc <= '0;
      end else if (mtime_wr) begin
         mtime <= merge(mtime, data_i, be_i);
         presc <= '0;
      end else if (!stop_i) begin
         if (presc == PMAX) begin
            presc <= '0;
            mtime <= mtime + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   // Per-hart compare and software-interrupt registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
         msip <= '0;
      end else begin
         for (int h = 0; h < NUM_HARTS; h++) begin
            if (cmp_wr[h]) mtimecmp[h] <= merge(mtimecmp[h], data_i, be_i);
            if (sip_wr[h] && be_i[0]) msip[h] <= data_i[0];
         end
      end
   end

   // Bus response: ack every request one cycle later; read data is the pre-update value.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_ready_o <= 1'b0;
         data_o       <= '0;
      end else begin
         data_ready_o <= en_i;
         data_o       <= (en_i && !we_i) ? rd_val : '0;
      end
   end

   // Registered interrupt lines, one cycle behind the register state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tmr_irq_o <= '0;
         sft_irq_o <= '0;
      end else begin
         for (int h = 0; h < NUM_HARTS; h++) begin
            tmr_irq_o[h] <= (mtime >= mtimecmp[h]);
            sft_irq_o[h] <= msip[h];
         end
      end
   end

endmodule

// File: tb/tb_clint_mh.sv
// tb/tb_clint_mh.sv - directed self-checking bench for clint_mh
module tb_clint_mh;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  addr = '0;
   logic [7:0]  be = '0;
   logic [63:0] wdata = '0;
   logic        stop = 1'b0;

   logic [63:0] a_data, b_data;
   logic        a_ack, b_ack;
   logic [1:0]  a_tmr, a_sft, b_tmr, b_sft;

   int n_assert = 0;
   int n_fail   = 0;
   logic [63:0] first;

   clint_mh #(.XLEN(64), .NUM_HARTS(2), .ADDR_W(4), .TICK_DIV(1)) u_a (
      .clk_i(clk), .rst_i(rst), .en_i(en), .we_i(we), .addr_i(addr), .be_i(be),
      .data_i(wdata), .data_o(a_data), .data_ready_o(a_ack), .stop_i(stop),
      .tmr_irq_o(a_tmr), .sft_irq_o(a_sft));

   clint_mh #(.XLEN(64), .NUM_HARTS(2), .ADDR_W(4), .TICK_DIV(4)) u_b (
      .clk_i(clk), .rst_i(rst), .en_i(en), .we_i(we), .addr_i(addr), .be_i(be),
      .data_i(wdata), .data_o(b_data), .data_ready_o(b_ack), .stop_i(stop),
      .tmr_irq_o(b_tmr), .sft_irq_o(b_sft));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One bus request driven at a negedge; returns at the next negedge (ack cycle).
   task automatic req(input logic w, input logic [3:0] a, input logic [7:0] b, input logic [63:0] d);
      en = 1'b1; we = w; addr = a; be = b; wdata = d;
      @(negedge clk);
      en = 1'b0; we = 1'b0; be = '0; wdata = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #2;
      chk("rst_a_ack", {63'b0, a_ack}, 64'd0);
      chk("rst_a_data", a_data, 64'd0);
      chk("rst_a_irq", {60'b0, a_tmr, a_sft}, 64'd0);
      chk("rst_b_irq", {60'b0, b_tmr, b_sft}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // back-to-back reads of mtime on the TICK_DIV=1 instance
      req(1'b0, 4'd0, 8'h00, 64'd0);
      first = a_data;
      chk("a_first_small", {63'b0, (first < 64'd3)}, 64'd1);
      chk("a_ack_rd", {63'b0, a_ack}, 64'd1);
      for (int k = 1; k < 4; k++) begin
         req(1'b0, 4'd0, 8'h00, 64'd0);
         chk("a_mtime_incr", a_data, first + 64'(k));
      end
      req(1'b0, 4'd1, 8'h00, 64'd0);
      chk("a_cmp0_reset", a_data, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("a_irq_idle", {60'b0, a_tmr, a_sft}, 64'd0);
      idle(1);
      chk("a_ack_drop", {63'b0, a_ack}, 64'd0);
      chk("a_data_idle", a_data, 64'd0);

      // prescaled tick: load 0, 20 idle cycles, read
      req(1'b1, 4'd0, 8'hFF, 64'd0);
      chk("wr_ack", {63'b0, a_ack}, 64'd1);
      chk("wr_data0", a_data, 64'd0);
      idle(20);
      req(1'b0, 4'd0, 8'h00, 64'd0);
      chk("b_mtime_div4", b_data, 64'd5);
      chk("a_mtime_div1", a_data, 64'd20);
      stop = 1'b1;
      idle(10);
      req(1'b0, 4'd0, 8'h00, 64'd0);
      chk("b_mtime_stop", b_data, 64'd5);
      chk("a_mtime_stop", a_data, 64'd21);
      stop = 1'b0;

      // timer interrupt on hart 1
      req(1'b1, 4'd0, 8'hFF, 64'd90);
      req(1'b1, 4'd2, 8'hFF, 64'd100);
      idle(8);
      chk("tmr_before", {62'b0, a_tmr}, 64'd0);
      idle(1);
      chk("tmr_not_early", {62'b0, a_tmr}, 64'd0);
      idle(1);
      chk("tmr_rise", {62'b0, a_tmr}, 64'd2);
      chk("b_tmr_low", {62'b0, b_tmr}, 64'd0);
      req(1'b1, 4'd2, 8'hFF, 64'd200);
      chk("tmr_hold", {62'b0, a_tmr}, 64'd2);
      idle(1);
      chk("tmr_drop", {62'b0, a_tmr}, 64'd0);

      // partial write to mtimecmp[0]
      req(1'b1, 4'd1, 8'h0F, 64'h1111_2222_3333_4444);
      req(1'b0, 4'd1, 8'h00, 64'd0);
      chk("cmp0_partial", a_data, 64'hFFFF_FFFF_3333_4444);
      chk("b_cmp0_partial", b_data, 64'hFFFF_FFFF_3333_4444);

      // software interrupt on hart 0
      req(1'b1, 4'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("sft_lag", {62'b0, a_sft}, 64'd0);
      idle(1);
      chk("sft_set", {62'b0, a_sft}, 64'd1);
      req(1'b0, 4'd3, 8'h00, 64'd0);
      chk("msip_read", a_data, 64'd1);
      req(1'b1, 4'd3, 8'hFF, 64'd0);
      idle(1);
      chk("sft_clr", {62'b0, a_sft}, 64'd0);

      // mtime wrap
      req(1'b1, 4'd0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE);
      idle(2);
      req(1'b0, 4'd0, 8'h00, 64'd0);
      chk("mtime_wrap", a_data, 64'd0);
      chk("b_mtime_nowrap", b_data, 64'hFFFF_FFFF_FFFF_FFFE);

      // unmapped accesses
      req(1'b0, 4'd7, 8'h00, 64'd0);
      chk("unmap_rd", a_data, 64'd0);
      chk("unmap_rd_ack", {63'b0, a_ack}, 64'd1);
      req(1'b1, 4'd7, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("unmap_wr_ack", {63'b0, a_ack}, 64'd1);
      req(1'b0, 4'd1, 8'h00, 64'd0);
      chk("unmap_cmp0", a_data, 64'hFFFF_FFFF_3333_4444);
      req(1'b0, 4'd4, 8'h00, 64'd0);
      chk("unmap_msip1", a_data, 64'd0);

      // reset in the ack cycle of a read
      en = 1'b1; we = 1'b0; addr = 4'd2;
      @(posedge clk);
      #1;
      en = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_kill_ack", {63'b0, a_ack}, 64'd0);
      chk("rst_kill_data", a_data, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_rel_ack", {63'b0, a_ack}, 64'd0);
      idle(1);
      chk("rst_rel_ack2", {63'b0, a_ack}, 64'd0);
      req(1'b0, 4'd2, 8'h00, 64'd0);
      chk("rst_cmp1", a_data, 64'hFFFF_FFFF_FFFF_FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/clint_mh.md
Name: clint_mh

Overview:
- Multi-hart Core Local Interruptor, the parametrised successor of the single-hart CLINT.
- Holds one shared 64-bit mtime, plus one mtimecmp and one msip register per hart.
- mtime advances on a programmable prescaled tick instead of every CPU clock. A stall input freezes it.
- Sits on the core's memory-mapped device bus and drives per-hart timer and software interrupt lines into each core's CSR/trap logic.

Parameters:
- XLEN, 64, bus data width; only 64 is supported.
- NUM_HARTS, 2, number of harts served (1..8).
- ADDR_W, 4, width of the word address; must satisfy 2^ADDR_W >= 1+2*NUM_HARTS.
- TICK_DIV, 1, CPU clocks per mtime increment (>=1).

Ports:
- clk_i  input  1  CPU clock.
- rst_i  input  1  asynchronous active-high reset.
- en_i  input  1  bus request strobe, one cycle per access.
- we_i  input  1  write when 1, read when 0; sampled with en_i.
- addr_i  input  ADDR_W  64-bit word index.
- be_i  input  XLEN/8  byte enables for writes; ignored on reads.
- data_i  input  XLEN  write data.
- data_o  output  XLEN  read data.
- data_ready_o  output  1  access acknowledge.
- stop_i  input  1  debug halt; freezes mtime and the prescaler.
- tmr_irq_o  output  NUM_HARTS  per-hart machine timer interrupt.
- sft_irq_o  output  NUM_HARTS  per-hart machine software interrupt.

Behaviour:
- Address map, in words:
  - 0: mtime.
  - 1+h: mtimecmp[h], for h = 0..NUM_HARTS-1.
  - 1+NUM_HARTS+h: msip[h]. Only bit 0 is implemented; reads return bits 63:1 as 0.
  - Any other index is unmapped.
- Reset (asynchronous, all state):
  - mtime = 0, prescaler = 0.
  - every mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, every msip = 0.
  - data_o = 0, data_ready_o = 0, tmr_irq_o = 0, sft_irq_o = 0.
  - Reset asserted mid-access discards the access; no ack is issued after reset release.
- Bus timing:
  - Every en_i cycle is acked: data_ready_o = 1 in exactly the next cycle, for one cycle.
  - Back-to-back requests are accepted every cycle.
  - Read: data_o in the ack cycle holds the register value sampled in the request cycle, i.e. before any same-cycle increment.
  - Write: data_o = 0 in the ack cycle.
  - In non-ack cycles data_o = 0.
- Writes:
  - Byte-merged: for each byte lane with be_i = 1 the register takes data_i, other bytes keep their value.
  - Writes to unmapped indices are dropped but still acked.
  - Reads of unmapped indices return 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while stop_i = 0.
  - At the clock where it equals TICK_DIV-1 it wraps to 0 and mtime increments by 1.
  - With TICK_DIV = 1, mtime increments every cycle.
  - mtime wraps from 2^64-1 to 0.
- Simultaneous events:
  - A write to mtime takes priority over the tick in that cycle. mtime takes the merged data_i, not data+1, and the prescaler is cleared to 0.
  - Writes to mtimecmp or msip never affect the prescaler or mtime.
- stop_i = 1: prescaler and mtime hold. Bus writes to mtime still take effect.
- Interrupts (registered, one-cycle lag):
  - Each clock, tmr_irq_o[h] <= (mtime >= mtimecmp[h]), unsigned 64-bit compare on current register values.
  - Each clock, sft_irq_o[h] <= msip[h][0].
  - There is no zero-gating of mtimecmp; the reset value of all-ones keeps irq low.
  - tmr_irq_o is level: it stays high until mtimecmp is raised above mtime or mtime wraps.

Test Plan:
- Reset release with NUM_HARTS = 2, TICK_DIV = 1, reading index 0 on consecutive requests -> values strictly increase by 1 per cycle from a small count; all irq outputs 0; reading index 1 returns 64'hFFFF_FFFF_FFFF_FFFF.
- TICK_DIV = 4, write mtime = 0 with be = 8'hFF, then idle 20 cycles and read -> mtime = 5 (priority load, prescaler cleared, 20/4 ticks); stop_i held 10 cycles leaves mtime unchanged.
- Write mtimecmp[1] = 100 at mtime = 90 with TICK_DIV = 1 -> tmr_irq_o = 2'b10 rises exactly 1 cycle after mtime reaches 100; tmr_irq_o[0] stays 0; writing mtimecmp[1] = 200 drops it 1 cycle later.
- Partial write to mtimecmp[0] with be = 8'h0F, data = 64'h1111_2222_3333_4444 -> readback 64'hFFFF_FFFF_3333_4444.
- Write msip[0] = 64'hFFFF_FFFF_FFFF_FFFF (index 3) -> sft_irq_o = 2'b01 one cycle later; readback = 1; writing 0 clears it.
- Load mtime = 64'hFFFF_FFFF_FFFF_FFFE -> after 2 ticks mtime = 0. Unmapped index 7 read -> returns 0 with ack; unmapped write -> acked with no state change. Reset pulse mid-read -> no ack after reset release.
